// File: rtl/cbrt_sched_pkg.sv
// Shared definitions for the cbrt job scheduler: FSM state codes and default widths
// used by the scheduler, the engine and the bench.
package cbrt_sched_pkg;

  localparam int A_W_DEF = 8;
  localparam int R_W_DEF = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_HOLD  = ST_HOLD,
    S_WAIT  = ST_WAIT,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/cbrt_sched_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the client
// that was not granted last.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = last_i ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/cbrt_sched.sv
// Shares one cbrt engine between two clients: arbitrates, drives the engine
// start/busy handshake, guards it with a watchdog and routes results back.
module cbrt_sched
  import cbrt_sched_pkg::*;
#(
  parameter int A_W     = A_W_DEF,
  parameter int R_W     = R_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           c0_req,
  input  logic [A_W-1:0] c0_a,
  output logic           c0_ack,
  output logic           c0_done,
  output logic [R_W-1:0] c0_res,
  output logic           c0_err,
  input  logic           c1_req,
  input  logic [A_W-1:0] c1_a,
  output logic           c1_ack,
  output logic           c1_done,
  output logic [R_W-1:0] c1_res,
  output logic           c1_err,
  output logic           eng_start,
  output logic [A_W-1:0] eng_a,
  input  logic           eng_busy,
  input  logic [R_W-1:0] eng_res,
  output logic           idle
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e               state_q, state_d;
  logic                 last_q, last_d;
  logic                 owner_q, owner_d;
  logic [WD_W-1:0]      wdog_q, wdog_d;
  logic [A_W-1:0]       eng_a_q, eng_a_d;
  logic [R_W-1:0]       rslt_q, rslt_d;
  logic                 terr_q, terr_d;
  logic                 start_q, start_d;
  logic                 idle_q, idle_d;
  logic [1:0]           ack_q, ack_d;
  logic [1:0]           done_q, done_d;
  logic [1:0]           err_q, err_d;
  logic [1:0][R_W-1:0]  res_q, res_d;
  logic [1:0]           gnt;

  rr_arb2 u_arb (
    .req_i  ({c1_req, c0_req}),
    .last_i (last_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    wdog_d  = wdog_q;
    eng_a_d = eng_a_q;
    rslt_d  = rslt_q;
    terr_d  = terr_q;
    start_d = 1'b0;
    ack_d   = '0;
    done_d  = '0;
    err_d   = '0;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (|gnt) begin
          owner_d = gnt[1];
          last_d  = gnt[1];
          eng_a_d = gnt[1] ? c1_a : c0_a;
          ack_d   = gnt;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        start_d = 1'b1;
        state_d = S_HOLD;
      end
      // Engine raises busy a cycle after start, so busy is not trusted here.
      S_HOLD: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!eng_busy) begin
          rslt_d  = eng_res;
          terr_d  = 1'b0;
          state_d = S_DONE;
        end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
          rslt_d  = '0;
          terr_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      // Result is committed to the client together with its done pulse.
      S_DONE: begin
        done_d[owner_q] = 1'b1;
        err_d[owner_q]  = terr_q;
        res_d[owner_q]  = rslt_q;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      wdog_q  <= '0;
      eng_a_q <= '0;
      rslt_q  <= '0;
      terr_q  <= 1'b0;
      start_q <= 1'b0;
      idle_q  <= 1'b1;
      ack_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      wdog_q  <= wdog_d;
      eng_a_q <= eng_a_d;
      rslt_q  <= rslt_d;
      terr_q  <= terr_d;
      start_q <= start_d;
      idle_q  <= idle_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  assign c0_ack    = ack_q[0];
  assign c1_ack    = ack_q[1];
  assign c0_done   = done_q[0];
  assign c1_done   = done_q[1];
  assign c0_err    = err_q[0];
  assign c1_err    = err_q[1];
  assign c0_res    = res_q[0];
  assign c1_res    = res_q[1];
  assign eng_start = start_q;
  assign eng_a     = eng_a_q;
  assign idle      = idle_q;

endmodule

// File: doc/cbrt_sched.md
Name: cbrt_sched

Overview:
- Round-robin job scheduler that shares one cbrt engine (and, through it, the single 16-bit adder) between two requesters.
- Accepts one operand per request, sequences the engine's start/busy handshake, and routes the result back to the issuing client.
- Watchdog aborts a job if the engine never drops busy.
- Sits between client logic and the cbrt instance; the adder stays wired directly to the engine.

Parameters:
- A_W, 8, operand width (engine input a)
- R_W, 4, result width (engine output res)
- TIMEOUT, 64, max WAIT cycles before the job is aborted with error

Ports:
- clk  in  1  system clock, posedge
- rst  in  1  asynchronous, active-high reset
- c0_req  in  1  client 0 request; held high until c0_ack
- c0_a  in  A_W  client 0 operand; valid while c0_req
- c0_ack  out  1  one-cycle pulse: c0 operand latched
- c0_done  out  1  one-cycle pulse: c0 result valid
- c0_res  out  R_W  c0 result; holds last value until next c0_done
- c0_err  out  1  valid with c0_done; 1 = timed out, res=0
- c1_req, c1_a, c1_ack, c1_done, c1_res, c1_err: same as c0, for client 1
- eng_start  out  1  engine start pulse
- eng_a  out  A_W  engine operand, stable from ISSUE until DONE
- eng_busy  in  1  engine busy
- eng_res  in  R_W  engine result
- idle  out  1  high in IDLE state

Behaviour:
- Reset: every output 0 (idle=1), state IDLE, last_grant=1 (so client 0 wins the first tie), wdog=0.
- All outputs are registered.
- IDLE:
  - no req: stay.
  - any req: winner = sole requester; if both, the client != last_grant.
  - Latch eng_a <= winner's a, owner <= winner, last_grant <= winner.
  - Pulse winner's ack in the same cycle as the transition; go ISSUE.
- ISSUE: eng_start=1 for exactly one cycle -> HOLD.
- HOLD: eng_start=0; eng_busy ignored here because the engine raises busy one cycle late -> WAIT; wdog cleared.
- WAIT:
  - eng_busy==0: capture eng_res into owner's res, err=0 -> DONE.
  - else wdog++.
  - wdog==TIMEOUT-1 with busy still high: owner res=0, err=1 -> DONE.
- DONE:
  - Pulse owner's done for 1 cycle -> IDLE.
  - New requests are not arbitrated until the next cycle in IDLE.
- Latency: ack (T) -> start (T+1) -> earliest done (T+4). Engine compute time adds directly.
- Requests arriving while not IDLE are not acked; the client keeps req high.
- A client may re-request in the cycle after its done. Fairness holds: with both requesting continuously, grants alternate 0,1,0,1.
- req dropped before ack: no job, no ack.
- Owner's operand change after ack: ignored (already latched).
- Non-owner outputs (done/err) stay 0; its res keeps its previous value.
- rst mid-job: immediate return to IDLE, outputs 0, no done pulse. The engine shares rst, so it resets too.
- eng_busy low already in the first WAIT cycle: valid, done at T+4.
- wdog is wide enough for TIMEOUT: $clog2(TIMEOUT+1) bits.

Decomposition:
- Shared package: state encodings (IDLE, ISSUE, HOLD, WAIT, DONE as 3-bit localparams) and default A_W/R_W, so the bench and the engine agree.
- One sub-module is natural: rr_arb2. Combinational two-way round-robin pick from (req0, req1, last_grant), outputting gnt[1:0]. The FSM and watchdog stay in cbrt_sched.

Test Plan:
- c0_req, a=27, c1 idle -> c0_ack one cycle, eng_start one cycle later, c0_done with c0_res=3, c0_err=0; c1_done never asserts.
- c1_req a=64 alone -> c1_res=4; then c0 a=0 -> c0_res=0; then c0 a=255 -> c0_res=6.
- c0 and c1 assert req in the same cycle after reset (a0=8, a1=125) -> c0 served first (res 2), then c1 (res 5); eng_a never changes mid-job.
- Both hold req for 6 jobs -> ack order 0,1,0,1,0,1; no two eng_start pulses fewer than 4 cycles apart.
- Assert rst during WAIT of a c0 job -> no c0_done; all outputs 0 next cycle; a fresh c1 request afterward completes correctly.
- Stub engine holds eng_busy=1 forever, TIMEOUT=64 -> c0_done with c0_err=1 and c0_res=0, exactly 64 WAIT cycles after entering WAIT; scheduler returns to IDLE.
